// File: rtl/cci_mpf_prim_gen_multi_write_if.sv
// Shared CCI-P style types and the command/data/c1Tx bundle
// for the multi-line write generator.
package cci_mpf_gmw_pkg;
  typedef logic [41:0]  t_cci_clAddr;
  typedef logic [1:0]   t_cci_clLen;
  typedef logic [1:0]   t_cci_clNum;
  typedef logic [15:0]  t_cci_mdata;
  typedef logic [511:0] t_cci_clData;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h1,
    eREQ_WRLINE_M = 4'h2
  } t_cci_c1_req;

  typedef struct packed {
    t_cci_c1_req req_type;
    t_cci_clAddr addr;
    t_cci_clLen  cl_len;
    logic        sop;
    t_cci_mdata  mdata;
  } t_cci_mpf_c1_ReqMemHdr;

  typedef struct packed {
    t_cci_mpf_c1_ReqMemHdr hdr;
    t_cci_clData           data;
    logic                  valid;
  } t_if_cci_mpf_c1_Tx;
endpackage

interface cci_mpf_prim_gen_multi_write_if;
  import cci_mpf_gmw_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  t_cci_clAddr       cmd_addr;
  t_cci_clLen        cmd_len;
  t_cci_mdata        cmd_mdata;
  logic              data_valid;
  t_cci_clData       data;
  logic              data_ready;
  logic              c1TxAlmFull;
  t_if_cci_mpf_c1_Tx c1Tx;
  logic              packetActive;
  t_cci_clNum        nextBeatNum;
  logic              error;

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    output cmd_mdata, data_valid, data,
    output c1TxAlmFull,
    input  cmd_ready, data_ready, c1Tx,
    input  packetActive, nextBeatNum, error
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    input  cmd_mdata, data_valid, data,
    input  c1TxAlmFull,
    output cmd_ready, data_ready, c1Tx,
    output packetActive, nextBeatNum, error
  );
endinterface

// File: rtl/cci_mpf_prim_gen_multi_write.sv
// Splits a multi-line write command into per-line c1Tx beats.
// Define CCI_MPF_GEN_MULTI_WRITE_CHECK_EN for command checking.
module cci_mpf_prim_gen_multi_write
  import cci_mpf_gmw_pkg::*;
(
  input logic clk,
  input logic reset,
  cci_mpf_prim_gen_multi_write_if.slave bus
);

  typedef enum logic {IDLE, BURST} t_state;

  t_state            state_q, state_d;
  t_cci_clAddr       addr_q, addr_d;
  t_cci_clLen        len_q, len_d;
  t_cci_mdata        mdata_q, mdata_d;
  t_cci_clNum        beat_q, beat_d;
  t_if_cci_mpf_c1_Tx tx_q, tx_d;

  logic fire;
  logic last;
  logic ready;
  logic accept;

  always_comb begin
    fire = (state_q == BURST)
         & bus.data_valid
         & ~bus.c1TxAlmFull
         & ~reset;
    last   = fire & (beat_q == len_q);
    ready  = ~reset & ((state_q == IDLE) | last);
    accept = bus.cmd_valid & ready;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    mdata_d = mdata_q;
    beat_d  = beat_q;
    tx_d    = '0;

    if (fire) begin
      tx_d.valid        = 1'b1;
      tx_d.data         = bus.data;
      tx_d.hdr.req_type = eREQ_WRLINE_I;
      tx_d.hdr.cl_len   = len_q;
      tx_d.hdr.sop      = (beat_q == 2'd0);
      tx_d.hdr.mdata    = mdata_q;
      tx_d.hdr.addr     = {addr_q[41:2],
                           addr_q[1:0] | beat_q};
      beat_d = last ? 2'd0 : beat_q + 2'd1;
    end

    if (accept) begin
      state_d = BURST;
      addr_d  = bus.cmd_addr;
      len_d   = bus.cmd_len;
      mdata_d = bus.cmd_mdata;
    end else if (last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      mdata_q <= '0;
      beat_q  <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      mdata_q <= mdata_d;
      beat_q  <= beat_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.cmd_ready    = ready;
  assign bus.data_ready   = fire;
  assign bus.c1Tx         = tx_q;
  assign bus.nextBeatNum  = beat_q;
  assign bus.packetActive = (beat_q != 2'd0);

`ifdef CCI_MPF_GEN_MULTI_WRITE_CHECK_EN
  logic err_q;
  logic bad;

  // Length code 2 is undefined; multi-line packets must be aligned
  always_comb begin
    bad = 1'b0;
    unique case (bus.cmd_len)
      2'd1:    bad = bus.cmd_addr[0];
      2'd2:    bad = 1'b1;
      2'd3:    bad = |bus.cmd_addr[1:0];
      default: bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (accept && bad)
      err_q <= 1'b1;
  end

  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_cci_mpf_prim_gen_multi_write.sv
// Scoreboard bench for the multi-line write generator.
// Expected beats are queued by stimulus and checked by a monitor.
module tb_cci_mpf_prim_gen_multi_write;
  import cci_mpf_gmw_pkg::*;

`ifdef CCI_MPF_GEN_MULTI_WRITE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cci_mpf_prim_gen_multi_write_if bus ();

  cci_mpf_prim_gen_multi_write dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    t_cci_clAddr addr;
    t_cci_clLen  len;
    logic        sop;
    t_cci_mdata  md;
    t_cci_clData d;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic t_cci_clData mkd(input logic [31:0] v);
    return {16{v}};
  endfunction

  function automatic void check(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic push(input t_cci_clAddr a, input t_cci_clLen l,
                      input logic s, input t_cci_mdata m,
                      input logic [31:0] dv);
    exp_t e;
    e.addr = a; e.len = l; e.sop = s; e.md = m; e.d = mkd(dv);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input t_cci_clAddr a, input t_cci_clLen l,
                     input t_cci_mdata m);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_mdata = m;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Monitor: every valid c1Tx beat must match the queue head
  always @(negedge clk) begin
    if (bus.c1Tx.valid === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got addr %0h, queue empty",
                 bus.c1Tx.hdr.addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.c1Tx.hdr.addr !== e.addr ||
            bus.c1Tx.hdr.cl_len !== e.len ||
            bus.c1Tx.hdr.sop !== e.sop ||
            bus.c1Tx.hdr.mdata !== e.md ||
            bus.c1Tx.hdr.req_type !== eREQ_WRLINE_I ||
            bus.c1Tx.data !== e.d) begin
          n_fail++;
          $display("FAIL beat: got a=%0h l=%0d s=%0b m=%0h d=%0h t=%0h expected a=%0h l=%0d s=%0b m=%0h d=%0h",
                   bus.c1Tx.hdr.addr, bus.c1Tx.hdr.cl_len,
                   bus.c1Tx.hdr.sop, bus.c1Tx.hdr.mdata,
                   bus.c1Tx.data[31:0], bus.c1Tx.hdr.req_type,
                   e.addr, e.len, e.sop, e.md, e.d[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cmd_valid   = 1'b1;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.cmd_mdata   = '0;
    bus.data_valid  = 1'b1;
    bus.data        = '0;
    bus.c1TxAlmFull = 1'b0;
    step();
    step();
    check("rst_valid", bus.c1Tx.valid, 0);
    check("rst_nbn", bus.nextBeatNum, 0);
    check("rst_pa", bus.packetActive, 0);
    check("rst_err", bus.error, 0);
    check("rst_cready", bus.cmd_ready, 0);
    check("rst_dready", bus.data_ready, 0);
    bus.cmd_valid  = 1'b0;
    bus.data_valid = 1'b0;
    reset = 1'b0;
    step();

    // 4-line packet, continuous data
    for (int i = 0; i < 4; i++)
      push(42'h100 + 42'(i), 2'd3, (i == 0), 16'hA5A5,
           32'h100 + 32'(i));
    bus.data_valid = 1'b1;
    bus.data = mkd(32'h100);
    bus.cmd_valid = 1'b1;
    #1;
    check("idle_dready", bus.data_ready, 0);
    check("idle_cready", bus.cmd_ready, 1);
    cmd(42'h100, 2'd3, 16'hA5A5);
    for (int i = 0; i < 4; i++) begin
      bus.data = mkd(32'h100 + 32'(i));
      step();
      check("t1_valid", bus.c1Tx.valid, 1);
      if (i == 0) begin
        check("t1_nbn1", bus.nextBeatNum, 1);
        check("t1_pa1", bus.packetActive, 1);
      end
    end
    bus.data_valid = 1'b0;
    check("t1_nbn_end", bus.nextBeatNum, 0);
    check("t1_pa_end", bus.packetActive, 0);
    step();

    // 2-line packet with AlmFull stall after beat 0
    push(42'h204, 2'd1, 1'b1, 16'h0202, 32'h200);
    push(42'h205, 2'd1, 1'b0, 16'h0202, 32'h201);
    cmd(42'h204, 2'd1, 16'h0202);
    bus.data_valid = 1'b1;
    bus.data = mkd(32'h200);
    step();
    bus.data = mkd(32'h201);
    bus.c1TxAlmFull = 1'b1;
    #1;
    check("stall_dready", bus.data_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", bus.c1Tx.valid, 0);
      check("stall_nbn", bus.nextBeatNum, 1);
      check("stall_pa", bus.packetActive, 1);
    end
    bus.c1TxAlmFull = 1'b0;
    step();
    check("stall_rel_valid", bus.c1Tx.valid, 1);
    bus.data_valid = 1'b0;
    check("stall_nbn_end", bus.nextBeatNum, 0);
    step();

    // three back-to-back 1-line commands
    push(42'h010, 2'd0, 1'b1, 16'h0001, 32'h10);
    push(42'h020, 2'd0, 1'b1, 16'h0002, 32'h20);
    push(42'h030, 2'd0, 1'b1, 16'h0003, 32'h30);
    cmd(42'h010, 2'd0, 16'h0001);
    bus.data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data = mkd(32'h10 * 32'(i + 1));
      if (i < 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 42'h020 + 42'h10 * 42'(i);
        bus.cmd_len   = 2'd0;
        bus.cmd_mdata = 16'(i + 2);
        #1;
        check("b2b_cready", bus.cmd_ready, 1);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      step();
      check("b2b_valid", bus.c1Tx.valid, 1);
      check("b2b_pa", bus.packetActive, 0);
    end
    bus.data_valid = 1'b0;
    step();
    check("b2b_gap", bus.c1Tx.valid, 0);

    // illegal length code 2 still emits three beats
    push(42'h200, 2'd2, 1'b1, 16'h00E0, 32'h500);
    push(42'h201, 2'd2, 1'b0, 16'h00E0, 32'h501);
    push(42'h202, 2'd2, 1'b0, 16'h00E0, 32'h502);
    cmd(42'h200, 2'd2, 16'h00E0);
    bus.data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data = mkd(32'h500 + 32'(i));
      step();
    end
    bus.data_valid = 1'b0;
    check("err_len2", bus.error, 64'(EXP_ERR));
    step();
    step();
    check("err_sticky", bus.error, 64'(EXP_ERR));

    // reset in the middle of a 4-line packet
    push(42'h300, 2'd3, 1'b1, 16'h0033, 32'h300);
    push(42'h301, 2'd3, 1'b0, 16'h0033, 32'h301);
    cmd(42'h300, 2'd3, 16'h0033);
    bus.data_valid = 1'b1;
    bus.data = mkd(32'h300);
    step();
    bus.data = mkd(32'h301);
    step();
    bus.data = mkd(32'h302);
    reset = 1'b1;
    #1;
    check("mrst_cready", bus.cmd_ready, 0);
    check("mrst_dready", bus.data_ready, 0);
    step();
    check("mrst_valid", bus.c1Tx.valid, 0);
    check("mrst_nbn", bus.nextBeatNum, 0);
    check("mrst_pa", bus.packetActive, 0);
    check("mrst_err", bus.error, 0);
    reset = 1'b0;
    bus.data_valid = 1'b0;
    step();
    check("mrst_idle", bus.cmd_ready, 1);

    // misaligned 4-line packet after reset, starts with sop
    push(42'h101, 2'd3, 1'b1, 16'h0044, 32'h600);
    push(42'h101, 2'd3, 1'b0, 16'h0044, 32'h601);
    push(42'h103, 2'd3, 1'b0, 16'h0044, 32'h602);
    push(42'h103, 2'd3, 1'b0, 16'h0044, 32'h603);
    cmd(42'h101, 2'd3, 16'h0044);
    bus.data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data = mkd(32'h600 + 32'(i));
      step();
    end
    bus.data_valid = 1'b0;
    check("err_misalign", bus.error, 64'(EXP_ERR));

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      step();
    step();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
